// File: rtl/gonso_sequencer_if.sv
// Pattern-memory read port between the gonso sequencer (master) and the shared 64x8 pattern RAM (slave).
interface gonso_sequencer_if;
    logic       cs_n;
    logic [5:0] addr;
    logic [7:0] rdata;

    modport master (output cs_n, output addr, input rdata);
    modport slave  (input cs_n, input addr, output rdata);
endinterface

// File: rtl/gonso_sequencer.sv
// Serial pattern sequencer: fetches bytes from pattern RAM and shifts them out at a prescaled bit rate.
// Optional macro GONSO_SEQ_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module gonso_sequencer #(
    parameter int PSIZE = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             controller_en,
    input  logic [PSIZE-1:0] prescale,
    input  logic             polarity,
    input  logic [5:0]       w_first,
    input  logic [5:0]       w_last,
    input  logic [3:0]       w_count,
    input  logic             start,
    output logic             progress,
    output logic             done,
    output logic             dout,
    output logic             tick,
    gonso_sequencer_if.master mem
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

    state_t           state_reg;
    logic             progress_reg;
    logic             done_reg;
    logic             cs_n_reg;
    logic [5:0]       addr_reg;
    logic             tick_reg;
    logic             dout_reg;
    logic             rd_valid_reg;
    logic [7:0]       byte_buf_reg;
    logic [7:0]       shreg_reg;
    logic [2:0]       bit_cnt_reg;
    logic [PSIZE-1:0] cnt_reg;
    logic [PSIZE-1:0] pre_reg;
    logic             pol_reg;
    logic [5:0]       first_reg;
    logic [5:0]       last_reg;
    logic [3:0]       count_reg;
    logic [5:0]       word_reg;
    logic [3:0]       pass_reg;
    logic             last_byte_reg;

`ifdef GONSO_SEQ_LSB_FIRST_EN
    function automatic logic head_bit(input logic [7:0] b);
        return b[0];
    endfunction
    function automatic logic [7:0] advance(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction
`else
    function automatic logic head_bit(input logic [7:0] b);
        return b[7];
    endfunction
    function automatic logic [7:0] advance(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction
`endif

    // word_reg/pass_reg name the byte most recently requested from memory
    logic       is_final;
    logic [5:0] next_word;
    logic [3:0] next_pass;
    logic       load_byte;

    assign is_final  = (word_reg == last_reg) && (pass_reg == count_reg);
    assign next_word = (word_reg == last_reg) ? first_reg : word_reg + 6'd1;
    assign next_pass = (word_reg == last_reg) ? pass_reg + 4'd1 : pass_reg;
    assign load_byte = controller_en &&
                       ((state_reg == WAIT) ||
                        (state_reg == SHIFT && tick_reg && bit_cnt_reg == 3'd7 && !last_byte_reg));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            progress_reg  <= 1'b0;
            done_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            addr_reg      <= 6'd0;
            tick_reg      <= 1'b0;
            dout_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            byte_buf_reg  <= 8'd0;
            shreg_reg     <= 8'd0;
            bit_cnt_reg   <= 3'd0;
            cnt_reg       <= '0;
            pre_reg       <= '0;
            pol_reg       <= 1'b0;
            first_reg     <= 6'd0;
            last_reg      <= 6'd0;
            count_reg     <= 4'd0;
            word_reg      <= 6'd0;
            pass_reg      <= 4'd0;
            last_byte_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            tick_reg     <= 1'b0;
            rd_valid_reg <= ~cs_n_reg;
            if (rd_valid_reg)
                byte_buf_reg <= mem.rdata;

            if (state_reg != IDLE && !controller_en) begin
                state_reg    <= IDLE;
                progress_reg <= 1'b0;
                dout_reg     <= polarity;
            end else begin
                case (state_reg)
                    IDLE: begin
                        dout_reg <= polarity;
                        if (start && controller_en) begin
                            pre_reg      <= prescale;
                            pol_reg      <= polarity;
                            first_reg    <= w_first;
                            last_reg     <= w_last;
                            count_reg    <= w_count;
                            word_reg     <= w_first;
                            pass_reg     <= 4'd0;
                            addr_reg     <= w_first;
                            cs_n_reg     <= 1'b0;
                            progress_reg <= 1'b1;
                            state_reg    <= FETCH;
                        end
                    end
                    FETCH: state_reg <= WAIT;
                    WAIT: begin
                        shreg_reg   <= mem.rdata;
                        dout_reg    <= head_bit(mem.rdata) ^ pol_reg;
                        cnt_reg     <= '0;
                        bit_cnt_reg <= 3'd0;
                        tick_reg    <= (pre_reg == '0);
                        state_reg   <= SHIFT;
                    end
                    SHIFT: begin
                        if (tick_reg) begin
                            cnt_reg <= '0;
                            if (bit_cnt_reg == 3'd7) begin
                                if (last_byte_reg) begin
                                    state_reg    <= IDLE;
                                    progress_reg <= 1'b0;
                                    done_reg     <= 1'b1;
                                    dout_reg     <= polarity;
                                end else begin
                                    // next byte was prefetched into the buffer; no gap between bytes
                                    shreg_reg   <= byte_buf_reg;
                                    dout_reg    <= head_bit(byte_buf_reg) ^ pol_reg;
                                    bit_cnt_reg <= 3'd0;
                                    tick_reg    <= (pre_reg == '0);
                                end
                            end else begin
                                shreg_reg   <= advance(shreg_reg);
                                dout_reg    <= head_bit(advance(shreg_reg)) ^ pol_reg;
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                tick_reg    <= (pre_reg == '0);
                            end
                        end else begin
                            cnt_reg  <= cnt_reg + PSIZE'(1);
                            tick_reg <= ((cnt_reg + PSIZE'(1)) == pre_reg);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end

            // first cycle of every byte: request the following byte, if any
            if (load_byte) begin
                last_byte_reg <= is_final;
                if (!is_final) begin
                    word_reg <= next_word;
                    pass_reg <= next_pass;
                    addr_reg <= next_word;
                    cs_n_reg <= 1'b0;
                end
            end
        end
    end

    assign progress = progress_reg;
    assign done     = done_reg;
    assign dout     = dout_reg;
    assign tick     = tick_reg;
    assign mem.cs_n = cs_n_reg;
    assign mem.addr = addr_reg;

endmodule

// File: tb/tb_gonso_sequencer.sv
// Scoreboard bench for gonso_sequencer: a cycle-accurate behavioural model queues expected ticks, fetches and done pulses.
module tb_gonso_sequencer;
    localparam int PSIZE = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             controller_en = 1'b0;
    logic [PSIZE-1:0] prescale = '0;
    logic             polarity = 1'b0;
    logic [5:0]       w_first = 6'd0;
    logic [5:0]       w_last = 6'd0;
    logic [3:0]       w_count = 4'd0;
    logic             start = 1'b0;
    logic             progress, done, dout, tick;

    gonso_sequencer_if bus ();

    gonso_sequencer #(.PSIZE(PSIZE)) dut (
        .clk(clk), .reset(reset), .controller_en(controller_en), .prescale(prescale),
        .polarity(polarity), .w_first(w_first), .w_last(w_last), .w_count(w_count),
        .start(start), .progress(progress), .done(done), .dout(dout), .tick(tick),
        .mem(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pmem [64];
    always @(posedge clk) if (bus.cs_n == 1'b0) bus.rdata <= pmem[bus.addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int val; } ev_t;
    ev_t tick_q[$];
    ev_t addr_q[$];
    ev_t done_q[$];
    int  dout_exp[int];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: expand a sequence into the per-cycle events the spec's rules imply
    task automatic model_seq(input int t, input int f, input int l, input int n, input int p,
                             input int pol, output int done_c);
        int nb = 0;
        int w;
        int per = p + 1;
        logic [7:0] b;
        int bv;
        int sb;
        for (int ps = 0; ps <= n; ps++) begin
            w = f;
            while (1) begin
                addr_q.push_back('{(nb == 0) ? t + 1 : t + 3 + (nb - 1) * 8 * per, w});
                b = pmem[w];
                for (int k = 0; k < 8; k++) begin
`ifdef GONSO_SEQ_LSB_FIRST_EN
                    bv = int'(b[k]);
`else
                    bv = int'(b[7 - k]);
`endif
                    sb = t + 3 + (nb * 8 + k) * per;
                    for (int j = 0; j < per; j++) dout_exp[sb + j] = bv ^ pol;
                    tick_q.push_back('{sb + p, bv ^ pol});
                end
                nb++;
                if (w == l) break;
                w = (w + 1) % 64;
            end
        end
        done_c = t + 3 + nb * 8 * per;
        done_q.push_back('{done_c, pol});
    endtask

    task automatic prune(input int c);
        ev_t keep[$];
        int  drop[$];
        foreach (tick_q[i]) if (tick_q[i].cyc <= c) keep.push_back(tick_q[i]);
        tick_q = keep;
        keep.delete();
        foreach (addr_q[i]) if (addr_q[i].cyc <= c) keep.push_back(addr_q[i]);
        addr_q = keep;
        keep.delete();
        foreach (done_q[i]) if (done_q[i].cyc <= c) keep.push_back(done_q[i]);
        done_q = keep;
        foreach (dout_exp[k]) if (k > c) drop.push_back(k);
        foreach (drop[i]) dout_exp.delete(drop[i]);
    endtask

    task automatic start_seq(input int f, input int l, input int n, input int p, input int pol,
                             output int done_c, output int t);
        polarity      = pol[0];
        w_first       = 6'(f);
        w_last        = 6'(l);
        w_count       = 4'(n);
        prescale      = PSIZE'(p);
        controller_en = 1'b1;
        start         = 1'b1;
        t             = cyc;
        model_seq(t, f, l, n, p, pol, done_c);
        $display("seq cyc=%0d first=%0d last=%0d count=%0d prescale=%0d pol=%0d done_expected=%0d",
                 t, f, l, n, p, pol, done_c);
        @(posedge clk); #1;
        start    = 1'b0;
        // configuration is latched at start; scramble the live inputs
        w_first  = 6'($urandom);
        w_last   = 6'($urandom);
        w_count  = 4'($urandom);
        prescale = PSIZE'($urandom_range(0, 7));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int budget = 5000;
        while ((tick_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checks++;
        if (tick_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: pending ticks=%0d fetches=%0d done=%0d, expected 0",
                     name, tick_q.size(), addr_q.size(), done_q.size());
            tick_q.delete(); addr_q.delete(); done_q.delete(); dout_exp.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT events against the scoreboard, away from the active edge
    always @(negedge clk) begin
        ev_t e;
        if (tick === 1'b1) begin
            if (tick_q.size() == 0) chk("unexpected tick", 1, 0);
            else begin
                e = tick_q.pop_front();
                chk("tick cycle", cyc, e.cyc);
                chk("tick dout", int'(dout), e.val);
                chk("progress at tick", int'(progress), 1);
            end
        end
        if (bus.cs_n === 1'b0) begin
            if (addr_q.size() == 0) chk("unexpected fetch", 1, 0);
            else begin
                e = addr_q.pop_front();
                chk("fetch cycle", cyc, e.cyc);
                chk("fetch addr", int'(bus.addr), e.val);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) chk("unexpected done", 1, 0);
            else begin
                e = done_q.pop_front();
                chk("done cycle", cyc, e.cyc);
                chk("dout at done", int'(dout), e.val);
                chk("progress at done", int'(progress), 0);
            end
        end
        if (dout_exp.exists(cyc)) begin
            chk("dout bit", int'(dout), dout_exp[cyc]);
            dout_exp.delete(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout at cycle %0d", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int dc, t, c, f, l;
        foreach (pmem[i]) pmem[i] = 8'($urandom);
        pmem[0] = 8'hA5;
        pmem[1] = 8'h3C;

        // reset values, then idle level follows polarity
        polarity      = 1'b1;
        controller_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset progress", int'(progress), 0);
        chk("reset done", int'(done), 0);
        chk("reset cs_n", int'(bus.cs_n), 1);
        chk("reset addr", int'(bus.addr), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset dout", int'(dout), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("dout after reset release", int'(dout), 1);
        polarity = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic byte order, then prescale 3
        start_seq(0, 1, 0, 0, 0, dc, t);
        chk("progress at T+1", int'(progress), 1);
        drain("basic");
        start_seq(0, 1, 0, 3, 0, dc, t);
        drain("prescale");

        // wrapping range with two passes
        start_seq(62, 1, 1, 0, 0, dc, t);
        drain("wrap");

        // inverted polarity, idle level included
        polarity = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle dout polarity=1", int'(dout), 1);
        start_seq(0, 0, 0, 1, 1, dc, t);
        drain("polarity");

        // back-to-back: second start issued in the done cycle
        start_seq(5, 7, 0, 1, 0, dc, t);
        wait_cyc(dc);
        start_seq(40, 41, 1, 0, 0, dc, t);
        drain("back-to-back");

        // abort during bit 3 of byte 0
        start_seq(0, 3, 0, 3, 0, dc, t);
        c = t + 3 + 3 * 4 + 1;
        wait_cyc(c);
        controller_en = 1'b0;
        prune(c);
        @(posedge clk); #1;
        chk("abort progress", int'(progress), 0);
        chk("abort dout", int'(dout), 0);
        chk("abort done", int'(done), 0);
        chk("abort cs_n", int'(bus.cs_n), 1);
        controller_en = 1'b1;
        repeat (10) @(posedge clk);
        drain("abort");

        // start pulsed while shifting is ignored
        start_seq(10, 12, 0, 1, 1, dc, t);
        wait_cyc(t + 8);
        w_first  = 6'd20;
        w_last   = 6'd30;
        prescale = PSIZE'(0);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain("busy start");

        // reset mid-byte, then a fresh start replays from w_first
        start_seq(5, 8, 1, 2, 1, dc, t);
        c = t + 3 + 10 * 3 + 1;
        wait_cyc(c);
        reset = 1'b1;
        prune(c);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset progress", int'(progress), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset cs_n", int'(bus.cs_n), 1);
        chk("midreset addr", int'(bus.addr), 0);
        chk("midreset tick", int'(tick), 0);
        chk("midreset dout", int'(dout), 0);
        @(posedge clk); #1;
        chk("dout after midreset", int'(dout), 1);
        start_seq(5, 8, 1, 2, 1, dc, t);
        drain("replay");

        // randomized sequences
        for (int i = 0; i < 6; i++) begin
            f = int'($urandom_range(0, 63));
            l = (f + int'($urandom_range(0, 5))) % 64;
            start_seq(f, l, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)), dc, t);
            drain("random");
        end

        chk("scoreboard empty", tick_q.size() + addr_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
